pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 70 +++++++
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle of pipeline-status inputs and pipeline-register controls exchanged
// between the five-stage datapath and the hazard sequencer.
//   Status from the datapath:
//     id_rs/id_rt, id_rs_used/id_rt_used : sources read by the ID instruction
//     ex_valid, ex_memread, ex_regwrt,
//     ex_write_reg                        : EX instruction (load / writer)
//     mem_valid, mem_branchtake, mem_jump,
//     mem_halt, mem_access                : MEM instruction
//     dmem_stall, dmem_done, imem_stall   : memory handshakes
//   Controls back to the datapath:
//     *_en  : pipeline register load enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//     *_nop : load a NOP instead of the upstream value
//     redirect, halted, stall_cnt, flush_cnt
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        ex_valid;
  logic        ex_memread;
  logic        ex_regwrt;
  logic [2:0]  ex_write_reg;
  logic        mem_valid;
  logic        mem_branchtake;
  logic        mem_jump;
  logic        mem_halt;
  logic        mem_access;
  logic        dmem_stall;
  logic        dmem_done;
  logic        imem_stall;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_nop;
  logic        idex_nop;
  logic        exmem_nop;
  logic        memwb_nop;
  logic        redirect;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // The datapath side drives status and consumes controls
  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used,
           ex_valid, ex_memread, ex_regwrt, ex_write_reg,
           mem_valid, mem_branchtake, mem_jump, mem_halt, mem_access,
           dmem_stall, dmem_done, imem_stall,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_nop, idex_nop, exmem_nop, memwb_nop,
           redirect, halted, stall_cnt, flush_cnt
  );

  // The hazard sequencer consumes status and drives controls
  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used,
           ex_valid, ex_memread, ex_regwrt, ex_write_reg,
           mem_valid, mem_branchtake, mem_jump, mem_halt, mem_access,
           dmem_stall, dmem_done, imem_stall,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_nop, idex_nop, exmem_nop, memwb_nop,
           redirect, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the five-stage pipeline. Decides, every
// cycle, which pipeline registers load, which load a NOP, and whether the PC
// takes the MEM-stage redirect target. Tracks multi-cycle data-memory stalls
// and HALT with a small FSM, and keeps saturating stall/flush counters.
//   clk  : pipeline clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : pipe_hazard_ctrl_if.slave (status in, controls/counters out)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {RUN, DSTALL, HALT} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_stallCnt;
  logic [15:0] r_flushCnt;

  logic w_dataStall, w_haltReq, w_redirectReq, w_loadUse;
  logic w_pcEn, w_ifidEn, w_idexEn, w_exmemEn, w_memwbEn;
  logic w_ifidNop, w_idexNop, w_exmemNop, w_memwbNop;
  logic w_redirect;

  // Raw hazard conditions seen this cycle; priority is applied further down.
  // The load-use check only fires for a real load that writes a register the
  // ID instruction actually reads.
  always_comb begin
    w_dataStall   = bus.mem_access & bus.mem_valid & bus.dmem_stall;
    w_haltReq     = bus.mem_valid & bus.mem_halt;
    w_redirectReq = bus.mem_valid & (bus.mem_branchtake | bus.mem_jump);
    w_loadUse     = bus.ex_valid & bus.ex_memread & bus.ex_regwrt &
                    ((bus.id_rs_used & (bus.id_rs == bus.ex_write_reg)) |
                     (bus.id_rt_used & (bus.id_rt == bus.ex_write_reg)));
  end

  // Pipeline control decode. Everything advances by default; the first
  // matching hazard in RUN overrides that. A data stall freezes everything
  // up to EX/MEM and pushes a bubble into MEM/WB until memory reports done.
  // Reset overrides all of it so the datapath sees NOPs everywhere.
  always_comb begin
    w_pcEn      = 1'b1;
    w_ifidEn    = 1'b1;
    w_idexEn    = 1'b1;
    w_exmemEn   = 1'b1;
    w_memwbEn   = 1'b1;
    w_ifidNop   = 1'b0;
    w_idexNop   = 1'b0;
    w_exmemNop  = 1'b0;
    w_memwbNop  = 1'b0;
    w_redirect  = 1'b0;
    w_nextState = r_state;
    case (r_state)
      RUN: begin
        if (w_dataStall) begin
          w_pcEn      = 1'b0;
          w_ifidEn    = 1'b0;
          w_idexEn    = 1'b0;
          w_exmemEn   = 1'b0;
          w_memwbNop  = 1'b1;
          w_nextState = DSTALL;
        end else if (w_haltReq) begin
          w_pcEn      = 1'b0;
          w_ifidNop   = 1'b1;
          w_idexNop   = 1'b1;
          w_exmemNop  = 1'b1;
          w_nextState = HALT;
        end else if (w_redirectReq) begin
          w_redirect  = 1'b1;
          w_ifidNop   = 1'b1;
          w_idexNop   = 1'b1;
          w_exmemNop  = 1'b1;
        end else if (w_loadUse) begin
          w_pcEn      = 1'b0;
          w_ifidEn    = 1'b0;
          w_idexNop   = 1'b1;
        end else if (bus.imem_stall) begin
          w_pcEn      = 1'b0;
          w_ifidNop   = 1'b1;
        end
      end
      DSTALL: begin
        if (!bus.dmem_done) begin
          w_pcEn      = 1'b0;
          w_ifidEn    = 1'b0;
          w_idexEn    = 1'b0;
          w_exmemEn   = 1'b0;
          w_memwbNop  = 1'b1;
        end else begin
          w_nextState = RUN;
        end
      end
      HALT: begin
        w_pcEn    = 1'b0;
        w_ifidEn  = 1'b0;
        w_idexEn  = 1'b0;
        w_exmemEn = 1'b0;
        w_memwbEn = 1'b0;
      end
      default: w_nextState = RUN;
    endcase
    if (!rst) begin
      w_pcEn      = 1'b0;
      w_ifidEn    = 1'b0;
      w_idexEn    = 1'b0;
      w_exmemEn   = 1'b0;
      w_memwbEn   = 1'b0;
      w_ifidNop   = 1'b1;
      w_idexNop   = 1'b1;
      w_exmemNop  = 1'b1;
      w_memwbNop  = 1'b1;
      w_redirect  = 1'b0;
      w_nextState = RUN;
    end
  end

  // State and performance counters. A stall cycle is any non-HALT cycle that
  // holds the PC; a flush is any redirect cycle. Both stop at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_stallCnt <= 16'd0;
      r_flushCnt <= 16'd0;
    end else begin
      r_state <= w_nextState;
      if ((r_state != HALT) && !w_pcEn && (r_stallCnt != 16'hFFFF))
        r_stallCnt <= r_stallCnt + 16'd1;
      if (w_redirect && (r_flushCnt != 16'hFFFF))
        r_flushCnt <= r_flushCnt + 16'd1;
    end
  end

  assign bus.pc_en     = w_pcEn;
  assign bus.ifid_en   = w_ifidEn;
  assign bus.idex_en   = w_idexEn;
  assign bus.exmem_en  = w_exmemEn;
  assign bus.memwb_en  = w_memwbEn;
  assign bus.ifid_nop  = w_ifidNop;
  assign bus.idex_nop  = w_idexNop;
  assign bus.exmem_nop = w_exmemNop;
  assign bus.memwb_nop = w_memwbNop;
  assign bus.redirect  = w_redirect;
  assign bus.halted    = (r_state == HALT);
  assign bus.stall_cnt = r_stallCnt;
  assign bus.flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Drives the hazard sequencer through directed hazard scenarios and a long
// randomized run, comparing every cycle against a table-driven model of the
// hazard priority rules and of the stall/flush counters.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  // Abstract model state: is the core halted, is a data access outstanding,
  // and the counter values as plain integers.
  bit   mHalted;
  bit   mDBusy;
  int   mStall;
  int   mFlush;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Controls packed as {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb nop,
  // redirect, halted}
  function automatic logic [10:0] observedControls();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_nop, bus.idex_nop, bus.exmem_nop, bus.memwb_nop,
            bus.redirect, bus.halted};
  endfunction

  // Expected control pattern, straight from the hazard table: each situation
  // maps to one fixed pattern, earlier lines taking priority.
  function automatic logic [10:0] modelControls();
    bit dataStall, haltReq, redir, loadUse;
    dataStall = bus.mem_access && bus.mem_valid && bus.dmem_stall;
    haltReq   = bus.mem_valid && bus.mem_halt;
    redir     = bus.mem_valid && (bus.mem_branchtake || bus.mem_jump);
    loadUse   = bus.ex_valid && bus.ex_memread && bus.ex_regwrt &&
                ((bus.id_rs_used && bus.id_rs == bus.ex_write_reg) ||
                 (bus.id_rt_used && bus.id_rt == bus.ex_write_reg));
    if (!rst)              return {5'b00000, 4'b1111, 2'b00};
    if (mHalted)           return {5'b00000, 4'b0000, 2'b01};
    if (mDBusy)            return bus.dmem_done ? {5'b11111, 4'b0000, 2'b00}
                                                : {5'b00001, 4'b0001, 2'b00};
    if (dataStall)         return {5'b00001, 4'b0001, 2'b00};
    if (haltReq)           return {5'b01111, 4'b1110, 2'b00};
    if (redir)             return {5'b11111, 4'b1110, 2'b10};
    if (loadUse)           return {5'b00111, 4'b0100, 2'b00};
    if (bus.imem_stall)    return {5'b01111, 4'b1000, 2'b00};
    return {5'b11111, 4'b0000, 2'b00};
  endfunction

  // Advance the model across one rising edge given this cycle's controls
  task automatic modelClock(input logic [10:0] ctl);
    bit dataStall, haltReq;
    if (!rst) return;
    dataStall = bus.mem_access && bus.mem_valid && bus.dmem_stall;
    haltReq   = bus.mem_valid && bus.mem_halt;
    if (!mHalted && !ctl[10]) mStall = (mStall < 65535) ? mStall + 1 : 65535;
    if (ctl[1])               mFlush = (mFlush < 65535) ? mFlush + 1 : 65535;
    if (mHalted) begin
      mHalted = 1'b1;
    end else if (mDBusy) begin
      if (bus.dmem_done) mDBusy = 1'b0;
    end else if (dataStall) begin
      mDBusy = 1'b1;
    end else if (haltReq) begin
      mHalted = 1'b1;
    end
  endtask

  // All status inputs idle
  task automatic clearInputs();
    bus.id_rs = 3'd0;          bus.id_rt = 3'd0;
    bus.id_rs_used = 1'b0;     bus.id_rt_used = 1'b0;
    bus.ex_valid = 1'b0;       bus.ex_memread = 1'b0;
    bus.ex_regwrt = 1'b0;      bus.ex_write_reg = 3'd0;
    bus.mem_valid = 1'b0;      bus.mem_branchtake = 1'b0;
    bus.mem_jump = 1'b0;       bus.mem_halt = 1'b0;
    bus.mem_access = 1'b0;     bus.dmem_stall = 1'b0;
    bus.dmem_done = 1'b0;      bus.imem_stall = 1'b0;
  endtask

  // Random status with biases chosen so every hazard shows up regularly;
  // small register numbers make load-use matches frequent.
  task automatic applyStimulus();
    bus.id_rs          = 3'($urandom_range(0, 7));
    bus.id_rt          = 3'($urandom_range(0, 7));
    bus.id_rs_used     = ($urandom_range(0, 1) == 1);
    bus.id_rt_used     = ($urandom_range(0, 1) == 1);
    bus.ex_valid       = ($urandom_range(0, 9) < 7);
    bus.ex_memread     = ($urandom_range(0, 9) < 4);
    bus.ex_regwrt      = ($urandom_range(0, 9) < 7);
    bus.ex_write_reg   = 3'($urandom_range(0, 7));
    bus.mem_valid      = ($urandom_range(0, 9) < 7);
    bus.mem_branchtake = ($urandom_range(0, 9) == 0);
    bus.mem_jump       = ($urandom_range(0, 19) == 0);
    bus.mem_halt       = ($urandom_range(0, 39) == 0);
    bus.mem_access     = ($urandom_range(0, 9) < 4);
    bus.dmem_stall     = ($urandom_range(0, 9) < 3);
    bus.dmem_done      = ($urandom_range(0, 9) < 4);
    bus.imem_stall     = ($urandom_range(0, 4) == 0);
  endtask

  // One clock cycle: inputs are already set at the falling edge; controls
  // are sampled 1 ns later, the model steps at the rising edge, and the
  // registered outputs are checked at the next falling edge.
  task automatic stepCycle(input string tag, input bit doCheck, output logic [10:0] seen);
    logic [10:0] expCtl;
    expCtl = modelControls();
    #1;
    seen = observedControls();
    if (doCheck) checkOutput($sformatf("%s/ctl", tag), 32'(seen), 32'(expCtl));
    @(posedge clk);
    modelClock(expCtl);
    @(negedge clk);
    if (doCheck) begin
      checkOutput($sformatf("%s/stall_cnt", tag), 32'(bus.stall_cnt), mStall);
      checkOutput($sformatf("%s/flush_cnt", tag), 32'(bus.flush_cnt), mFlush);
    end
  endtask

  // Assert reset at a falling edge and check the asynchronous response
  // before any clock edge, then hold one cycle and release.
  task automatic doReset(input string tag);
    rst = 1'b0;
    mHalted = 1'b0;
    mDBusy  = 1'b0;
    mStall  = 0;
    mFlush  = 0;
    #1;
    checkOutput($sformatf("%s/rst_ctl", tag), 32'(observedControls()), 32'(modelControls()));
    checkOutput($sformatf("%s/rst_nops", tag),
                32'({bus.ifid_nop, bus.idex_nop, bus.exmem_nop, bus.memwb_nop}), 32'hF);
    checkOutput($sformatf("%s/rst_stall", tag), 32'(bus.stall_cnt), 32'd0);
    checkOutput($sformatf("%s/rst_flush", tag), 32'(bus.flush_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Main sequence: directed scenarios, random run, halt, saturation
  initial begin
    logic [10:0] seen;
    testCount = 0;
    failCount = 0;
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    doReset("init");

    // Load-use: LD r3 in EX, ADD reading r3 through rt in ID
    bus.ex_valid = 1'b1;  bus.ex_memread = 1'b1;  bus.ex_regwrt = 1'b1;
    bus.ex_write_reg = 3'd3;
    bus.id_rs = 3'd1;     bus.id_rs_used = 1'b1;
    bus.id_rt = 3'd3;     bus.id_rt_used = 1'b1;
    stepCycle("lu", 1, seen);
    checkOutput("lu/pattern", 32'(seen), 32'({5'b00111, 4'b0100, 2'b00}));
    bus.ex_valid = 1'b0;
    stepCycle("lu_next", 1, seen);
    checkOutput("lu_next/en", 32'(seen[10:6]), 32'h1F);
    checkOutput("lu/stall_total", 32'(bus.stall_cnt), 32'd1);

    // Redirect with a concurrent load-use match: redirect wins
    bus.ex_valid = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_branchtake = 1'b1;
    stepCycle("redir", 1, seen);
    checkOutput("redir/pattern", 32'(seen), 32'({5'b11111, 4'b1110, 2'b10}));
    checkOutput("redir/flush_total", 32'(bus.flush_cnt), 32'd1);
    checkOutput("redir/stall_total", 32'(bus.stall_cnt), 32'd1);

    // Data stall for three cycles, then the completion cycle
    clearInputs();
    bus.mem_valid = 1'b1; bus.mem_access = 1'b1; bus.dmem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepCycle("dstall", 1, seen);
      checkOutput("dstall/pattern", 32'(seen), 32'({5'b00001, 4'b0001, 2'b00}));
    end
    bus.dmem_stall = 1'b0; bus.dmem_done = 1'b1;
    stepCycle("ddone", 1, seen);
    checkOutput("ddone/pattern", 32'(seen), 32'({5'b11111, 4'b0000, 2'b00}));
    checkOutput("ddone/stall_total", 32'(bus.stall_cnt), 32'd4);
    clearInputs();
    stepCycle("drun", 1, seen);
    checkOutput("drun/en", 32'(seen[10:6]), 32'h1F);

    // Reset while waiting on data memory returns to RUN
    bus.mem_valid = 1'b1; bus.mem_access = 1'b1; bus.dmem_stall = 1'b1;
    stepCycle("dst_rst", 1, seen);
    clearInputs();
    doReset("dst_rst");
    stepCycle("dst_rst_run", 1, seen);
    checkOutput("dst_rst/run_en", 32'(seen[10:6]), 32'h1F);

    // Randomized run against the model, recovering from halts via reset
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      stepCycle("rand", 1, seen);
      if (mHalted && ($urandom_range(0, 7) == 0)) doReset("rand_halt");
      else if ($urandom_range(0, 299) == 0)       doReset("rand_mid");
    end

    // Halt: flush upstream, halted from the next cycle, frozen thereafter
    clearInputs();
    doReset("halt_pre");
    bus.mem_valid = 1'b1; bus.mem_halt = 1'b1;
    stepCycle("halt", 1, seen);
    checkOutput("halt/pattern", 32'(seen), 32'({5'b01111, 4'b1110, 2'b00}));
    for (int i = 0; i < 22; i++) begin
      applyStimulus();
      stepCycle("halted", 1, seen);
      checkOutput("halted/flag_en", 32'({seen[10:6], seen[0]}), 32'h01);
    end
    clearInputs();
    doReset("halt_rst");
    stepCycle("halt_rst_run", 1, seen);
    checkOutput("halt_rst/run", 32'(seen), 32'({5'b11111, 4'b0000, 2'b00}));

    // Saturation: fetch stalled long enough to pin the stall counter
    doReset("sat_pre");
    bus.imem_stall = 1'b1;
    for (int i = 0; i < 65600; i++) stepCycle("sat", 0, seen);
    checkOutput("sat/stall_max", 32'(bus.stall_cnt), 32'hFFFF);
    stepCycle("sat_hold", 1, seen);
    checkOutput("sat_hold/stall_max", 32'(bus.stall_cnt), 32'hFFFF);
    doReset("sat_rst");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
